// File: rtl/d8m_bayer_pipe.sv
// d8m_bayer_pipe: Bayer capture with frame/line tracking and 2x2 demosaic to RGB.
// Optional crop window enabled by defining D8M_CROP_EN (adds CROP_* parameters).
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | capture disabled, waiting for iSTART
// S_ARMED  | waiting for a clean FVAL rising edge
// S_ACTIVE | capturing a frame; FVAL fall ends it
module d8m_bayer_pipe #(
  parameter int DW      = 12,
  parameter int MAX_W   = 1024,
  parameter int BAYER   = 0
`ifdef D8M_CROP_EN
  ,
  parameter int CROP_X0 = 0,
  parameter int CROP_Y0 = 0,
  parameter int CROP_W  = 640,
  parameter int CROP_H  = 480
`endif
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [DW-1:0] iDATA,
  input  logic          iFVAL,
  input  logic          iLVAL,
  input  logic          iSTART,
  input  logic          iEND,
  output logic [DW-1:0] oRed,
  output logic [DW-1:0] oGreen,
  output logic [DW-1:0] oBlue,
  output logic          oDVAL,
  output logic [15:0]   oX_Cont,
  output logic [15:0]   oY_Cont,
  output logic [31:0]   oFrame_Cont,
  output logic          oBUSY,
  output logic          oLINE_OVF
);

  localparam int          AW    = $clog2(MAX_W);
  localparam logic [15:0] MAX_X = 16'(MAX_W);
  localparam logic [1:0]  BP    = 2'(BAYER);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE} state_t;

  state_t        state;
  logic          end_seen;
  logic [DW-1:0] d_r;
  logic          fval_r, fval_rr, lval_r, lval_rr;
  logic [15:0]   x_cnt, y_cnt;
  logic [DW-1:0] mem [MAX_W];
  logic [DW-1:0] top_prev, top_cur, bot_prev, bot_cur;
  logic [15:0]   s1_x, s1_y;
  logic          s1_v;

  logic fval_rise, fval_fall, lval_fall, act, samp_ok;

  assign fval_rise = fval_r & ~fval_rr;
  assign fval_fall = ~fval_r & fval_rr;
  assign lval_fall = ~lval_r & lval_rr;
  // The first sample of a frame may arrive in the same cycle the rise is seen.
  assign act       = (state == S_ACTIVE) || (state == S_ARMED && fval_rise && !iEND);
  assign samp_ok   = act && lval_r && (x_cnt < MAX_X);
  assign oBUSY     = (state != S_IDLE);

  // Input registers plus one extra stage of the framing signals for edge detect
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      d_r     <= '0;
      fval_r  <= 1'b0;
      fval_rr <= 1'b0;
      lval_r  <= 1'b0;
      lval_rr <= 1'b0;
    end else begin
      d_r     <= iDATA;
      fval_r  <= iFVAL;
      fval_rr <= fval_r;
      lval_r  <= iLVAL;
      lval_rr <= lval_r;
    end
  end

  // Capture FSM, frame counter and sticky overflow flag
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= S_IDLE;
      end_seen    <= 1'b0;
      oFrame_Cont <= '0;
      oLINE_OVF   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iSTART && !iEND) begin
            state     <= S_ARMED;
            oLINE_OVF <= 1'b0;
          end
        end
        S_ARMED: begin
          if (iEND) begin
            state <= S_IDLE;
          end else if (fval_rise) begin
            state    <= S_ACTIVE;
            end_seen <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (iEND) end_seen <= 1'b1;
          if (fval_fall) begin
            oFrame_Cont <= oFrame_Cont + 32'd1;
            state       <= (end_seen || iEND) ? S_IDLE : S_ARMED;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (act && lval_r && (x_cnt >= MAX_X)) oLINE_OVF <= 1'b1;
    end
  end

  // Pixel coordinates of the sample currently in the input register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (act && lval_r) begin
        if (x_cnt < MAX_X) x_cnt <= x_cnt + 16'd1;
      end else begin
        x_cnt <= '0;
      end
      if (state == S_ARMED && fval_rise) y_cnt <= '0;
      else if (act && lval_fall)         y_cnt <= y_cnt + 16'd1;
    end
  end

  // Line buffer: overwrite with the current line after its old value is read
  always_ff @(posedge iCLK) begin
    if (samp_ok) mem[x_cnt[AW-1:0]] <= d_r;
  end

  // Window stage: shift previous/current line columns
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_v     <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      top_prev <= '0;
      top_cur  <= '0;
      bot_prev <= '0;
      bot_cur  <= '0;
    end else begin
      s1_v <= samp_ok && (x_cnt != 16'd0) && (y_cnt != 16'd0);
      if (samp_ok) begin
        top_cur  <= mem[x_cnt[AW-1:0]];
        top_prev <= top_cur;
        bot_cur  <= d_r;
        bot_prev <= bot_cur;
        s1_x     <= x_cnt;
        s1_y     <= y_cnt;
      end
    end
  end

  logic [DW-1:0] win  [4];
  logic [1:0]    cidx [4];
  logic [DW-1:0] red, blue;
  logic [DW:0]   gsum;
  logic [15:0]   ox, oy;

  assign ox = s1_x - 16'd1;
  assign oy = s1_y - 16'd1;

  // Route each window sample to its colour by Bayer phase
  always_comb begin
    win[0]  = top_prev;
    win[1]  = top_cur;
    win[2]  = bot_prev;
    win[3]  = bot_cur;
    cidx[0] = {~s1_y[0], ~s1_x[0]} ^ BP;
    cidx[1] = {~s1_y[0],  s1_x[0]} ^ BP;
    cidx[2] = { s1_y[0], ~s1_x[0]} ^ BP;
    cidx[3] = { s1_y[0],  s1_x[0]} ^ BP;
    red  = '0;
    blue = '0;
    gsum = '0;
    for (int i = 0; i < 4; i++) begin
      if (cidx[i] == 2'd0)      red  = win[i];
      else if (cidx[i] == 2'd3) blue = win[i];
      else                      gsum = gsum + {1'b0, win[i]};
    end
  end

`ifdef D8M_CROP_EN
  localparam logic [31:0] CX_LO = 32'(CROP_X0);
  localparam logic [31:0] CX_HI = 32'(CROP_X0 + CROP_W);
  localparam logic [31:0] CY_LO = 32'(CROP_Y0);
  localparam logic [31:0] CY_HI = 32'(CROP_Y0 + CROP_H);
  logic in_win;
  assign in_win = ({16'd0, ox} >= CX_LO) && ({16'd0, ox} < CX_HI) &&
                  ({16'd0, oy} >= CY_LO) && ({16'd0, oy} < CY_HI);
`endif

  // Output register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDVAL   <= 1'b0;
      oRed    <= '0;
      oGreen  <= '0;
      oBlue   <= '0;
      oX_Cont <= '0;
      oY_Cont <= '0;
    end else begin
`ifdef D8M_CROP_EN
      oDVAL <= s1_v && in_win;
`else
      oDVAL <= s1_v;
`endif
      if (s1_v) begin
        oRed   <= red;
        oGreen <= gsum[DW:1];
        oBlue  <= blue;
`ifdef D8M_CROP_EN
        oX_Cont <= ox - 16'(CROP_X0);
        oY_Cont <= oy - 16'(CROP_Y0);
`else
        oX_Cont <= ox;
        oY_Cont <= oy;
`endif
      end
    end
  end

endmodule

// File: tb/tb_d8m_bayer_pipe.sv
// Scoreboard bench for d8m_bayer_pipe: three instances (RGGB, BGGR, RGGB with
// an 8-pixel line buffer) share one stimulus stream.
module tb_d8m_bayer_pipe;

  logic        clk = 1'b0;
  logic        rst, fval, lval, start, stop;
  logic [11:0] data;

  logic [11:0] r [3], g [3], b [3];
  logic        dv [3], busy [3], ovf [3];
  logic [15:0] ox [3], oy [3];
  logic [31:0] fc [3];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  for (genvar i = 0; i < 3; i++) begin : g_dut
`ifdef D8M_CROP_EN
    d8m_bayer_pipe #(.DW(12), .MAX_W(i == 2 ? 8 : 1024), .BAYER(i == 1 ? 3 : 0),
                     .CROP_X0(1), .CROP_Y0(1), .CROP_W(2), .CROP_H(2)) u_dut (
`else
    d8m_bayer_pipe #(.DW(12), .MAX_W(i == 2 ? 8 : 1024), .BAYER(i == 1 ? 3 : 0)) u_dut (
`endif
      .iCLK(clk), .iRST(rst), .iDATA(data), .iFVAL(fval), .iLVAL(lval),
      .iSTART(start), .iEND(stop),
      .oRed(r[i]), .oGreen(g[i]), .oBlue(b[i]), .oDVAL(dv[i]),
      .oX_Cont(ox[i]), .oY_Cont(oy[i]), .oFrame_Cont(fc[i]),
      .oBUSY(busy[i]), .oLINE_OVF(ovf[i]));
  end

  typedef struct {
    logic [15:0] x, y;
    logic [11:0] r, g, b;
    int          cyc;
  } exp_t;

  exp_t        sbq [3][$];
  int          n_cmp = 0, n_fail = 0;
  int          base = 0;
  bit          exp_on = 1'b0;
  int          dv_cnt [3] = '{0, 0, 0};
  logic [35:0] first_rgb [3];
  exp_t        mon_e;

  task automatic check(string nm, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  function automatic logic [11:0] px(int x, int y);
    return 12'(16 * y + x + base);
  endfunction

  // Expected output for a sample at (x,y), per instance
  task automatic push_exp(int x, int y);
    for (int i = 0; i < 3; i++) begin
      int mw  = (i == 2) ? 8 : 1024;
      int bay = (i == 1) ? 3 : 0;
      int ex, ey, gs;
      exp_t e;
      bit keep;
      if (x >= 1 && y >= 1 && x < mw) begin
        e.r = '0; e.b = '0; gs = 0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++) begin
            int xx = x - 1 + dx, yy = y - 1 + dy;
            int c  = (((yy % 2) * 2) + (xx % 2)) ^ bay;
            if (c == 0)      e.r = px(xx, yy);
            else if (c == 3) e.b = px(xx, yy);
            else             gs += int'(px(xx, yy));
          end
        e.g = 12'(gs / 2);
        ex = x - 1; ey = y - 1; keep = 1'b1;
`ifdef D8M_CROP_EN
        keep = (ex >= 1 && ex < 3 && ey >= 1 && ey < 3);
        ex -= 1; ey -= 1;
`endif
        e.x = 16'(ex); e.y = 16'(ey); e.cyc = cyc;
        if (keep) sbq[i].push_back(e);
      end
    end
  endtask

  // Monitor: compare each presented output with the scoreboard head
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i] === 1'b1) begin
        if (dv_cnt[i] == 0) first_rgb[i] = {r[i], g[i], b[i]};
        dv_cnt[i]++;
        if (sbq[i].size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL u%0d unexpected oDVAL at x=%0d y=%0d", i, ox[i], oy[i]);
        end else begin
          mon_e = sbq[i].pop_front();
          check($sformatf("u%0d x", i), 64'(ox[i]), 64'(mon_e.x));
          check($sformatf("u%0d y", i), 64'(oy[i]), 64'(mon_e.y));
          check($sformatf("u%0d red@%0d,%0d", i, mon_e.x, mon_e.y), 64'(r[i]), 64'(mon_e.r));
          check($sformatf("u%0d green@%0d,%0d", i, mon_e.x, mon_e.y), 64'(g[i]), 64'(mon_e.g));
          check($sformatf("u%0d blue@%0d,%0d", i, mon_e.x, mon_e.y), 64'(b[i]), 64'(mon_e.b));
          check($sformatf("u%0d latency", i), 64'(cyc - mon_e.cyc), 64'd3);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_end();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  // One frame of w x h pixels; optional start/end pulses in an inter-line gap
  task automatic send_frame(int w, int h, int start_at = -1, int end_at = -1,
                            bit chk_fall = 1'b0);
    fval = 1'b1; tick(); tick();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        lval = 1'b1; data = px(x, y);
        if (exp_on) push_exp(x, y);
        tick();
      end
      lval = 1'b0; data = '0;
      if (y == start_at) start = 1'b1;
      if (y == end_at)   stop  = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      tick();
    end
    tick();
    fval = 1'b0; tick();
    if (chk_fall) check("busy at fval fall edge", 64'(busy[0]), 64'd1);
    tick();
    if (chk_fall) check("busy one cycle later", 64'(busy[0]), 64'd0);
    repeat (4) tick();
  endtask

  task automatic check_all_zero(string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s u%0d dval", tag, i), 64'(dv[i]), 64'd0);
      check($sformatf("%s u%0d rgb", tag, i), 64'({r[i], g[i], b[i]}), 64'd0);
      check($sformatf("%s u%0d xy", tag, i), 64'({ox[i], oy[i]}), 64'd0);
      check($sformatf("%s u%0d frames", tag, i), 64'(fc[i]), 64'd0);
      check($sformatf("%s u%0d busy/ovf", tag, i), 64'({busy[i], ovf[i]}), 64'd0);
    end
  endtask

  int snap [3];

  initial begin
    rst = 1'b1; fval = 1'b0; lval = 1'b0; start = 1'b0; stop = 1'b0; data = '0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0; tick();

    // Full 4x4 frame, data = 16*y+x
    pulse_start();
    check("busy after start", 64'(busy[0]), 64'd1);
    exp_on = 1'b1; base = 0;
    send_frame(4, 4);
`ifdef D8M_CROP_EN
    for (int i = 0; i < 3; i++) check($sformatf("u%0d pulses frame1", i), 64'(dv_cnt[i]), 64'd4);
`else
    for (int i = 0; i < 3; i++) check($sformatf("u%0d pulses frame1", i), 64'(dv_cnt[i]), 64'd9);
    check("u0 first rgb", 64'(first_rgb[0]), 64'({12'd0, 12'd8, 12'd17}));
    check("u1 first rgb", 64'(first_rgb[1]), 64'({12'd17, 12'd8, 12'd0}));
    check("u2 first rgb", 64'(first_rgb[2]), 64'({12'd0, 12'd8, 12'd17}));
`endif
    check("frames after frame1", 64'(fc[0]), 64'd1);
    check("busy armed", 64'(busy[0]), 64'd1);

    // Disarm, then arm while FVAL is high mid-frame
    pulse_end();
    check("busy after end in armed", 64'(busy[0]), 64'd0);
    exp_on = 1'b0; base = 12'h100;
    send_frame(4, 4, 1);
    check("partial frame not counted", 64'(fc[0]), 64'd1);
    exp_on = 1'b1;
    send_frame(4, 4);
    check("full frame counted", 64'(fc[0]), 64'd2);

    // iEND mid-frame: frame completes, then IDLE
    base = 12'h300;
    send_frame(4, 4, -1, 1, 1'b1);
    check("frames after end frame", 64'(fc[0]), 64'd3);
    exp_on = 1'b0;
    send_frame(4, 4);
    check("ignored frame in idle", 64'(fc[0]), 64'd3);

    // Over-long lines
    pulse_start();
    exp_on = 1'b1; base = 12'h200;
    send_frame(10, 3);
    check("frames after long frame", 64'(fc[0]), 64'd4);
    check("u2 ovf set", 64'(ovf[2]), 64'd1);
    check("u0 ovf clear", 64'(ovf[0]), 64'd0);
    send_frame(4, 2);
    check("u2 ovf sticky", 64'(ovf[2]), 64'd1);
    pulse_end();
    check("u2 ovf sticky in idle", 64'(ovf[2]), 64'd1);
    pulse_start();
    check("u2 ovf cleared by start", 64'(ovf[2]), 64'd0);

    // Reset in the middle of the first line
    exp_on = 1'b0;
    fval = 1'b1; tick(); tick();
    for (int x = 0; x < 3; x++) begin lval = 1'b1; data = px(x, 0); tick(); end
    for (int i = 0; i < 3; i++) snap[i] = dv_cnt[i];
    rst = 1'b1; tick();
    check_all_zero("mid-line reset");
    rst = 1'b0; lval = 1'b0; fval = 1'b0;
    repeat (4) tick();
    check("idle after reset", 64'(busy[0]), 64'd0);
    for (int i = 0; i < 3; i++)
      check($sformatf("u%0d no output after reset", i), 64'(dv_cnt[i] - snap[i]), 64'd0);

    // Recovery frame
    pulse_start();
    exp_on = 1'b1; base = 12'h400;
    send_frame(4, 4);
    check("frames after recovery", 64'(fc[0]), 64'd1);

    repeat (5) tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("u%0d scoreboard drained", i), 64'(sbq[i].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
